// File: rtl/itlb_l2_tlb_req_tracker.sv
// ITLB -> L2 TLB request tracker.
// Allocates a tag per ITLB miss, issues one L2 TLB request per tag, matches
// responses back by tag and produces a one-cycle ITLB fill. Entries that are
// in flight when a flush arrives become ZOMBIE so their late response is
// absorbed without producing a fill.
// Optional build macro: ITLB_L2_TLB_REQ_COALESCE_EN merges a miss into an
// outstanding entry with the same vpn/asid instead of allocating a new one.
module itlb_l2_tlb_req_tracker #(
    parameter int TAG_COUNT  = 4,
    parameter int VPN_WIDTH  = 20,
    parameter int ASID_WIDTH = 16,
    parameter int PTE_WIDTH  = 32,
    localparam int TAG_WIDTH = $clog2(TAG_COUNT)
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  miss_valid,
    input  logic [VPN_WIDTH-1:0]  miss_vpn,
    input  logic [ASID_WIDTH-1:0] miss_asid,
    output logic                  miss_ready,
    output logic [TAG_WIDTH-1:0]  miss_tag,
    output logic                  miss_new,
    output logic                  l2_req_valid,
    output logic [VPN_WIDTH-1:0]  l2_req_vpn,
    output logic [ASID_WIDTH-1:0] l2_req_asid,
    output logic [TAG_WIDTH-1:0]  l2_req_tag,
    input  logic                  l2_req_ready,
    input  logic                  l2_resp_valid,
    input  logic [TAG_WIDTH-1:0]  l2_resp_tag,
    input  logic [PTE_WIDTH-1:0]  l2_resp_pte,
    input  logic                  l2_resp_superpage,
    input  logic                  l2_resp_fault,
    input  logic                  flush_valid,
    output logic                  fill_valid,
    output logic [VPN_WIDTH-1:0]  fill_vpn,
    output logic [ASID_WIDTH-1:0] fill_asid,
    output logic [PTE_WIDTH-1:0]  fill_pte,
    output logic                  fill_superpage,
    output logic                  fill_fault,
    output logic [TAG_WIDTH-1:0]  fill_tag,
    output logic                  busy
);

    typedef enum logic [1:0] {ST_FREE, ST_SEND, ST_WAIT, ST_ZOMBIE} state_e;

    state_e                state_q [TAG_COUNT];
    state_e                state_d [TAG_COUNT];
    logic [VPN_WIDTH-1:0]  vpn_q   [TAG_COUNT];
    logic [ASID_WIDTH-1:0] asid_q  [TAG_COUNT];

    logic [TAG_COUNT-1:0]  is_free;
    logic [TAG_COUNT-1:0]  is_send;
    logic [TAG_COUNT-1:0]  freeing;
    logic [TAG_COUNT-1:0]  match;

    logic                  alloc_found;
    logic [TAG_WIDTH-1:0]  alloc_idx;
    logic                  send_found;
    logic [TAG_WIDTH-1:0]  send_idx;
    logic                  hit_any;
    logic [TAG_WIDTH-1:0]  hit_idx;
    logic                  alloc_fire;
    logic                  req_fire;
    logic                  resp_fill;

    // Per-entry status flags; an entry being freed by a response this cycle
    // must not accept a coalesced miss.
    for (genvar gi = 0; gi < TAG_COUNT; gi++) begin : g_flags
        assign is_free[gi] = (state_q[gi] == ST_FREE);
        assign is_send[gi] = (state_q[gi] == ST_SEND);
        assign freeing[gi] = l2_resp_valid && (l2_resp_tag == TAG_WIDTH'(gi)) &&
                             ((state_q[gi] == ST_WAIT) || (state_q[gi] == ST_ZOMBIE));
        assign match[gi]   = miss_valid &&
                             ((state_q[gi] == ST_SEND) || (state_q[gi] == ST_WAIT)) &&
                             (vpn_q[gi] == miss_vpn) && (asid_q[gi] == miss_asid) &&
                             !freeing[gi];
    end

    // Lowest-index priority pick of the free entry, the send entry and the hit.
    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        send_found  = 1'b0;
        send_idx    = '0;
        hit_idx     = '0;
        for (int i = TAG_COUNT - 1; i >= 0; i--) begin
            if (is_free[i]) begin
                alloc_found = 1'b1;
                alloc_idx   = TAG_WIDTH'(i);
            end
            if (is_send[i]) begin
                send_found = 1'b1;
                send_idx   = TAG_WIDTH'(i);
            end
            if (match[i]) begin
                hit_idx = TAG_WIDTH'(i);
            end
        end
    end

`ifdef ITLB_L2_TLB_REQ_COALESCE_EN
    assign hit_any  = |match;
    assign miss_new = miss_valid && !hit_any;
`else
    assign hit_any  = 1'b0;
    assign miss_new = 1'b1;
`endif

    assign miss_ready   = !flush_valid && (hit_any || alloc_found);
    assign miss_tag     = hit_any ? hit_idx : alloc_idx;
    assign alloc_fire   = miss_valid && miss_ready && !hit_any;

    assign l2_req_valid = send_found;
    assign l2_req_vpn   = send_found ? vpn_q[send_idx]  : '0;
    assign l2_req_asid  = send_found ? asid_q[send_idx] : '0;
    assign l2_req_tag   = send_idx;
    assign req_fire     = l2_req_valid && l2_req_ready;

    // Only a response to a live WAIT entry outside a flush produces a fill.
    assign resp_fill    = l2_resp_valid && (state_q[l2_resp_tag] == ST_WAIT) && !flush_valid;
    assign busy         = !(&is_free);

    // Per-entry next state: allocation, request handshake, response, flush.
    always_comb begin
        for (int i = 0; i < TAG_COUNT; i++) begin
            state_d[i] = state_q[i];
            unique case (state_q[i])
                ST_FREE: begin
                    if (alloc_fire && (alloc_idx == TAG_WIDTH'(i))) state_d[i] = ST_SEND;
                end
                ST_SEND: begin
                    if (req_fire && (send_idx == TAG_WIDTH'(i)))
                        state_d[i] = flush_valid ? ST_ZOMBIE : ST_WAIT;
                    else if (flush_valid)
                        state_d[i] = ST_FREE;
                end
                ST_WAIT: begin
                    if (freeing[i])       state_d[i] = ST_FREE;
                    else if (flush_valid) state_d[i] = ST_ZOMBIE;
                end
                ST_ZOMBIE: begin
                    if (freeing[i]) state_d[i] = ST_FREE;
                end
                default: state_d[i] = ST_FREE;
            endcase
        end
    end

    // Entry state and fill registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < TAG_COUNT; i++) state_q[i] <= ST_FREE;
            fill_valid     <= 1'b0;
            fill_vpn       <= '0;
            fill_asid      <= '0;
            fill_pte       <= '0;
            fill_superpage <= 1'b0;
            fill_fault     <= 1'b0;
            fill_tag       <= '0;
        end else begin
            for (int i = 0; i < TAG_COUNT; i++) state_q[i] <= state_d[i];
            fill_valid <= resp_fill;
            if (resp_fill) begin
                fill_vpn       <= vpn_q[l2_resp_tag];
                fill_asid      <= asid_q[l2_resp_tag];
                fill_pte       <= l2_resp_pte;
                fill_superpage <= l2_resp_superpage;
                fill_fault     <= l2_resp_fault;
                fill_tag       <= l2_resp_tag;
            end
        end
    end

    // Capture the miss address into the newly allocated entry.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < TAG_COUNT; i++) begin
            if (alloc_fire && (alloc_idx == TAG_WIDTH'(i))) begin
                vpn_q[i]  <= miss_vpn;
                asid_q[i] <= miss_asid;
            end
        end
    end

endmodule

// File: tb/tb_itlb_l2_tlb_req_tracker.sv
// Directed-vector bench for itlb_l2_tlb_req_tracker (TAG_COUNT=4).
// Each table row is one clock cycle: inputs are applied after the falling
// edge and outputs are compared 1ns later, before the next rising edge.
module tb_itlb_l2_tlb_req_tracker;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        miss_valid;
    logic [19:0] miss_vpn;
    logic [15:0] miss_asid;
    logic        miss_ready;
    logic [1:0]  miss_tag;
    logic        miss_new;
    logic        l2_req_valid;
    logic [19:0] l2_req_vpn;
    logic [15:0] l2_req_asid;
    logic [1:0]  l2_req_tag;
    logic        l2_req_ready;
    logic        l2_resp_valid;
    logic [1:0]  l2_resp_tag;
    logic [31:0] l2_resp_pte;
    logic        l2_resp_superpage;
    logic        l2_resp_fault;
    logic        flush_valid;
    logic        fill_valid;
    logic [19:0] fill_vpn;
    logic [15:0] fill_asid;
    logic [31:0] fill_pte;
    logic        fill_superpage;
    logic        fill_fault;
    logic [1:0]  fill_tag;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    itlb_l2_tlb_req_tracker #(
        .TAG_COUNT (4),
        .VPN_WIDTH (20),
        .ASID_WIDTH(16),
        .PTE_WIDTH (32)
    ) dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .miss_valid       (miss_valid),
        .miss_vpn         (miss_vpn),
        .miss_asid        (miss_asid),
        .miss_ready       (miss_ready),
        .miss_tag         (miss_tag),
        .miss_new         (miss_new),
        .l2_req_valid     (l2_req_valid),
        .l2_req_vpn       (l2_req_vpn),
        .l2_req_asid      (l2_req_asid),
        .l2_req_tag       (l2_req_tag),
        .l2_req_ready     (l2_req_ready),
        .l2_resp_valid    (l2_resp_valid),
        .l2_resp_tag      (l2_resp_tag),
        .l2_resp_pte      (l2_resp_pte),
        .l2_resp_superpage(l2_resp_superpage),
        .l2_resp_fault    (l2_resp_fault),
        .flush_valid      (flush_valid),
        .fill_valid       (fill_valid),
        .fill_vpn         (fill_vpn),
        .fill_asid        (fill_asid),
        .fill_pte         (fill_pte),
        .fill_superpage   (fill_superpage),
        .fill_fault       (fill_fault),
        .fill_tag         (fill_tag),
        .busy             (busy)
    );

    typedef struct {
        logic        rst_n;
        logic        mv;
        logic [19:0] vpn;
        logic        rq_rdy;
        logic        rv;
        logic [1:0]  rtag;
        logic [31:0] pte;
        logic        flush;
        logic        e_ready;
        logic [1:0]  e_tag;
        logic        e_reqv;
        logic [1:0]  e_reqtag;
        logic [19:0] e_reqvpn;
        logic        e_fill;
        logic [19:0] e_fvpn;
        logic [31:0] e_fpte;
        logic        e_busy;
    } vec_t;

    localparam int NVEC = 36;
    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic rst_n, input logic mv, input logic [19:0] vpn,
        input logic rq_rdy, input logic rv, input logic [1:0] rtag,
        input logic [31:0] pte, input logic flush,
        input logic e_ready, input logic [1:0] e_tag,
        input logic e_reqv, input logic [1:0] e_reqtag, input logic [19:0] e_reqvpn,
        input logic e_fill, input logic [19:0] e_fvpn, input logic [31:0] e_fpte,
        input logic e_busy);
        vec_t v;
        v.rst_n = rst_n; v.mv = mv; v.vpn = vpn; v.rq_rdy = rq_rdy;
        v.rv = rv; v.rtag = rtag; v.pte = pte; v.flush = flush;
        v.e_ready = e_ready; v.e_tag = e_tag; v.e_reqv = e_reqv;
        v.e_reqtag = e_reqtag; v.e_reqvpn = e_reqvpn; v.e_fill = e_fill;
        v.e_fvpn = e_fvpn; v.e_fpte = e_fpte; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic clear_inputs();
        miss_valid = 1'b0; miss_vpn = '0; miss_asid = '0;
        l2_req_ready = 1'b0; l2_resp_valid = 1'b0; l2_resp_tag = '0;
        l2_resp_pte = '0; l2_resp_superpage = 1'b0; l2_resp_fault = 1'b0;
        flush_valid = 1'b0;
    endtask

    initial begin
        // rst mv vpn rdy rv rtag pte flush | ready tag reqv reqtag reqvpn fill fvpn fpte busy
        vecs[0]  = mk(1,0,20'h0,    0,0,0,32'h0,       0, 1,0,0,0,20'h0,     0,20'h0,    32'h0,       0);
        vecs[1]  = mk(1,1,20'h12345,0,0,0,32'h0,       0, 1,0,0,0,20'h0,     0,20'h0,    32'h0,       0);
        vecs[2]  = mk(1,0,20'h0,    1,0,0,32'h0,       0, 1,0,1,0,20'h12345, 0,20'h0,    32'h0,       1);
        vecs[3]  = mk(1,0,20'h0,    0,1,0,32'h0ABCD00F,0, 1,0,0,0,20'h0,     0,20'h0,    32'h0,       1);
        vecs[4]  = mk(1,0,20'h0,    0,0,0,32'h0,       0, 1,0,0,0,20'h0,     1,20'h12345,32'h0ABCD00F,0);
        vecs[5]  = mk(1,1,20'h100,  0,0,0,32'h0,       0, 1,0,0,0,20'h0,     0,20'h0,    32'h0,       0);
        vecs[6]  = mk(1,1,20'h101,  0,0,0,32'h0,       0, 1,1,1,0,20'h100,   0,20'h0,    32'h0,       1);
        vecs[7]  = mk(1,1,20'h102,  0,0,0,32'h0,       0, 1,2,1,0,20'h100,   0,20'h0,    32'h0,       1);
        vecs[8]  = mk(1,1,20'h103,  0,0,0,32'h0,       0, 1,3,1,0,20'h100,   0,20'h0,    32'h0,       1);
        vecs[9]  = mk(1,1,20'h104,  1,0,0,32'h0,       0, 0,0,1,0,20'h100,   0,20'h0,    32'h0,       1);
        vecs[10] = mk(1,1,20'h104,  1,0,0,32'h0,       0, 0,0,1,1,20'h101,   0,20'h0,    32'h0,       1);
        vecs[11] = mk(1,1,20'h104,  1,0,0,32'h0,       0, 0,0,1,2,20'h102,   0,20'h0,    32'h0,       1);
        vecs[12] = mk(1,1,20'h104,  0,1,2,32'h11111111,0, 0,0,1,3,20'h103,   0,20'h0,    32'h0,       1);
        vecs[13] = mk(1,1,20'h104,  0,0,0,32'h0,       0, 1,2,1,3,20'h103,   1,20'h102,  32'h11111111,1);
        vecs[14] = mk(1,1,20'h105,  1,0,0,32'h0,       1, 0,0,1,2,20'h104,   0,20'h0,    32'h0,       1);
        vecs[15] = mk(1,0,20'h0,    0,0,0,32'h0,       0, 1,0,0,0,20'h0,     0,20'h0,    32'h0,       1);
        vecs[16] = mk(1,0,20'h0,    0,1,1,32'h22222222,0, 1,0,0,0,20'h0,     0,20'h0,    32'h0,       1);
        vecs[17] = mk(1,0,20'h0,    0,1,0,32'h33333333,0, 1,0,0,0,20'h0,     0,20'h0,    32'h0,       1);
        vecs[18] = mk(1,0,20'h0,    0,1,2,32'h44444444,0, 1,0,0,0,20'h0,     0,20'h0,    32'h0,       1);
        vecs[19] = mk(1,0,20'h0,    0,0,0,32'h0,       0, 1,0,0,0,20'h0,     0,20'h0,    32'h0,       0);
        vecs[20] = mk(1,1,20'h200,  0,0,0,32'h0,       0, 1,0,0,0,20'h0,     0,20'h0,    32'h0,       0);
        vecs[21] = mk(1,0,20'h0,    1,0,0,32'h0,       0, 1,0,1,0,20'h200,   0,20'h0,    32'h0,       1);
        vecs[22] = mk(1,0,20'h0,    0,1,0,32'h55555555,1, 0,0,0,0,20'h0,     0,20'h0,    32'h0,       1);
        vecs[23] = mk(1,0,20'h0,    0,0,0,32'h0,       0, 1,0,0,0,20'h0,     0,20'h0,    32'h0,       0);
        vecs[24] = mk(1,1,20'h300,  0,0,0,32'h0,       0, 1,0,0,0,20'h0,     0,20'h0,    32'h0,       0);
        vecs[25] = mk(1,1,20'h301,  1,0,0,32'h0,       0, 1,1,1,0,20'h300,   0,20'h0,    32'h0,       1);
        vecs[26] = mk(1,1,20'h302,  0,0,0,32'h0,       0, 1,2,1,1,20'h301,   0,20'h0,    32'h0,       1);
        vecs[27] = mk(1,1,20'h303,  0,0,0,32'h0,       0, 1,3,1,1,20'h301,   0,20'h0,    32'h0,       1);
        vecs[28] = mk(1,1,20'h300,  0,1,0,32'h66666666,0, 0,0,1,1,20'h301,   0,20'h0,    32'h0,       1);
        vecs[29] = mk(1,1,20'h300,  0,0,0,32'h0,       0, 1,0,1,1,20'h301,   1,20'h300,  32'h66666666,1);
        vecs[30] = mk(0,0,20'h0,    0,0,0,32'h0,       0, 0,0,1,0,20'h300,   0,20'h0,    32'h0,       1);
        vecs[31] = mk(1,0,20'h0,    0,0,0,32'h0,       0, 1,0,0,0,20'h0,     0,20'h0,    32'h0,       0);
        vecs[32] = mk(1,0,20'h0,    0,1,2,32'h77777777,0, 1,0,0,0,20'h0,     0,20'h0,    32'h0,       0);
        vecs[33] = mk(1,1,20'h400,  0,0,0,32'h0,       0, 1,0,0,0,20'h0,     0,20'h0,    32'h0,       0);
        vecs[34] = mk(1,0,20'h0,    0,1,0,32'h88888888,0, 1,0,1,0,20'h400,   0,20'h0,    32'h0,       1);
        vecs[35] = mk(1,0,20'h0,    0,0,0,32'h0,       0, 1,0,1,0,20'h400,   0,20'h0,    32'h0,       1);

        clear_inputs();
        nRST = 1'b0;
        repeat (2) @(negedge CLK);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge CLK);
            nRST          = vecs[i].rst_n;
            miss_valid    = vecs[i].mv;
            miss_vpn      = vecs[i].vpn;
            miss_asid     = vecs[i].mv ? 16'h0001 : 16'h0000;
            l2_req_ready  = vecs[i].rq_rdy;
            l2_resp_valid = vecs[i].rv;
            l2_resp_tag   = vecs[i].rtag;
            l2_resp_pte   = vecs[i].pte;
            flush_valid   = vecs[i].flush;
            #1;
            $display("vec %0d: ready=%0b tag=%0d reqv=%0b reqtag=%0d fill=%0b busy=%0b",
                     i, miss_ready, miss_tag, l2_req_valid, l2_req_tag, fill_valid, busy);
            chk($sformatf("v%0d miss_ready", i), 32'(miss_ready), 32'(vecs[i].e_ready));
            if (vecs[i].mv && vecs[i].e_ready) begin
                chk($sformatf("v%0d miss_tag", i), 32'(miss_tag), 32'(vecs[i].e_tag));
                chk($sformatf("v%0d miss_new", i), 32'(miss_new), 32'd1);
            end
            chk($sformatf("v%0d l2_req_valid", i), 32'(l2_req_valid), 32'(vecs[i].e_reqv));
            chk($sformatf("v%0d l2_req_tag", i), 32'(l2_req_tag), 32'(vecs[i].e_reqtag));
            chk($sformatf("v%0d l2_req_vpn", i), 32'(l2_req_vpn), 32'(vecs[i].e_reqvpn));
            chk($sformatf("v%0d fill_valid", i), 32'(fill_valid), 32'(vecs[i].e_fill));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
            if (vecs[i].e_fill) begin
                chk($sformatf("v%0d fill_vpn", i), 32'(fill_vpn), 32'(vecs[i].e_fvpn));
                chk($sformatf("v%0d fill_pte", i), 32'(fill_pte), 32'(vecs[i].e_fpte));
                chk($sformatf("v%0d fill_asid", i), 32'(fill_asid), 32'h1);
            end
        end

        // Duplicate miss while the first is outstanding: coalesced when the
        // feature is built in, a second independent entry otherwise.
        @(negedge CLK);
        clear_inputs();
        nRST = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        $display("seq reset: miss_new=%0b fill_tag=%0d", miss_new, fill_tag);
        chk("rst fill_tag", 32'(fill_tag), 32'd0);
`ifdef ITLB_L2_TLB_REQ_COALESCE_EN
        chk("rst miss_new", 32'(miss_new), 32'd0);
`else
        chk("rst miss_new", 32'(miss_new), 32'd1);
`endif
        @(negedge CLK);
        miss_valid = 1'b1; miss_vpn = 20'h12345; miss_asid = 16'h0001;
        #1;
        $display("seq miss1: ready=%0b tag=%0d new=%0b", miss_ready, miss_tag, miss_new);
        chk("dup miss1 tag", 32'(miss_tag), 32'd0);
        chk("dup miss1 new", 32'(miss_new), 32'd1);
        @(negedge CLK);
        miss_valid = 1'b0; l2_req_ready = 1'b1;
        #1;
        $display("seq issue: reqv=%0b reqtag=%0d", l2_req_valid, l2_req_tag);
        chk("dup issue reqv", 32'(l2_req_valid), 32'd1);
        @(negedge CLK);
        l2_req_ready = 1'b0;
        miss_valid = 1'b1; miss_vpn = 20'h12345; miss_asid = 16'h0001;
        #1;
        $display("seq miss2: ready=%0b tag=%0d new=%0b", miss_ready, miss_tag, miss_new);
        chk("dup miss2 ready", 32'(miss_ready), 32'd1);
`ifdef ITLB_L2_TLB_REQ_COALESCE_EN
        chk("dup miss2 tag", 32'(miss_tag), 32'd0);
        chk("dup miss2 new", 32'(miss_new), 32'd0);
`else
        chk("dup miss2 tag", 32'(miss_tag), 32'd1);
        chk("dup miss2 new", 32'(miss_new), 32'd1);
`endif
        @(negedge CLK);
        miss_valid = 1'b0; miss_vpn = '0; miss_asid = '0;
        #1;
        $display("seq after miss2: reqv=%0b reqtag=%0d", l2_req_valid, l2_req_tag);
`ifdef ITLB_L2_TLB_REQ_COALESCE_EN
        chk("dup no second req", 32'(l2_req_valid), 32'd0);
`else
        chk("dup second req", 32'(l2_req_valid), 32'd1);
        chk("dup second req tag", 32'(l2_req_tag), 32'd1);
`endif
        @(negedge CLK);
        l2_resp_valid = 1'b1; l2_resp_tag = 2'd0; l2_resp_pte = 32'hCAFE0001;
        l2_resp_superpage = 1'b1; l2_resp_fault = 1'b1;
        #1;
        chk("dup fill before resp", 32'(fill_valid), 32'd0);
        @(negedge CLK);
        l2_resp_valid = 1'b0; l2_resp_superpage = 1'b0; l2_resp_fault = 1'b0;
        #1;
        $display("seq fill: fill=%0b vpn=0x%0h pte=0x%0h sp=%0b flt=%0b",
                 fill_valid, fill_vpn, fill_pte, fill_superpage, fill_fault);
        chk("dup fill valid", 32'(fill_valid), 32'd1);
        chk("dup fill vpn", 32'(fill_vpn), 32'h12345);
        chk("dup fill pte", 32'(fill_pte), 32'hCAFE0001);
        chk("dup fill superpage", 32'(fill_superpage), 32'd1);
        chk("dup fill fault", 32'(fill_fault), 32'd1);
        chk("dup fill tag", 32'(fill_tag), 32'd0);
        @(negedge CLK);
        #1;
        $display("seq end: fill=%0b busy=%0b", fill_valid, busy);
        chk("dup single fill", 32'(fill_valid), 32'd0);
`ifdef ITLB_L2_TLB_REQ_COALESCE_EN
        chk("dup busy end", 32'(busy), 32'd0);
`else
        chk("dup busy end", 32'(busy), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
